// File: rtl/seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : seq_checker
// Description : Receive-side checker for the 3-bit odd/prime-step counter
//               stream. The legal cycle is 1,2,3,5,7,1,... and 0 enters it
//               at 3. The checker samples din on en and checks every
//               transition against the successor table. It locks after
//               LOCK_N consecutive legal transitions. Once locked, it
//               unlocks after UNLOCK_N consecutive illegal transitions.
// Ports       : clock      - rising-edge clock
//               reset      - asynchronous active-high reset
//               en         - sample strobe, din valid when high
//               din[2:0]   - counter value, din[0] is MSB, din[2] is LSB
//               locked     - high while in LOCKED
//               err        - one-cycle pulse, illegal transition while LOCKED
//               err_count  - saturating count of err pulses
//               idx        - position of the last sampled legal code
//               wrap       - one-cycle pulse, legal 7->1 while LOCKED
// Revision    : 1.0 - initial release
// ============================================================================
module seq_checker #(
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       din,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       idx,
  output logic             wrap
);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       C_LOCK_N   = 4'(LOCK_N);
  localparam logic [3:0]       C_UNLOCK_N = 4'(UNLOCK_N);
  localparam logic [ERR_W-1:0] C_ERR_MAX  = {ERR_W{1'b1}};

  state_t           r_state;
  logic [2:0]       r_prev;
  logic             r_prev_v;
  logic [2:0]       r_good_cnt;
  logic [2:0]       r_bad_cnt;
  logic             r_err;
  logic [ERR_W-1:0] r_err_count;
  logic [2:0]       r_idx;
  logic             r_wrap;

  state_t           w_state_nxt;
  logic [2:0]       w_prev_nxt;
  logic             w_prev_v_nxt;
  logic [2:0]       w_good_nxt;
  logic [2:0]       w_bad_nxt;
  logic             w_err_nxt;
  logic [ERR_W-1:0] w_err_count_nxt;
  logic [2:0]       w_idx_nxt;
  logic             w_wrap_nxt;

  logic [2:0]       w_val;
  logic             w_legal;
  logic             w_is_code;
  logic [2:0]       w_code_idx;

  // din arrives MSB-first on bit 0; restore natural binary ordering.
  assign w_val = {din[0], din[1], din[2]};

  // Successor table, written as {prev, cur} in octal pairs.
  always_comb begin
    w_legal = 1'b0;
    case ({r_prev, w_val})
      6'o12, 6'o23, 6'o35, 6'o57, 6'o71, 6'o03: w_legal = 1'b1;
      default:                                  w_legal = 1'b0;
    endcase
  end

  // Position of a legal code within the cycle; 0, 4 and 6 have none.
  always_comb begin
    w_is_code  = 1'b1;
    w_code_idx = 3'd0;
    case (w_val)
      3'd1:    w_code_idx = 3'd0;
      3'd2:    w_code_idx = 3'd1;
      3'd3:    w_code_idx = 3'd2;
      3'd5:    w_code_idx = 3'd3;
      3'd7:    w_code_idx = 3'd4;
      default: w_is_code  = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_prev_nxt      = r_prev;
    w_prev_v_nxt    = r_prev_v;
    w_good_nxt      = r_good_cnt;
    w_bad_nxt       = r_bad_cnt;
    w_err_nxt       = 1'b0;
    w_err_count_nxt = r_err_count;
    w_idx_nxt       = r_idx;
    w_wrap_nxt      = 1'b0;

    if (en) begin
      // prev always follows din, so an illegal value resynchronises checking.
      w_prev_nxt   = w_val;
      w_prev_v_nxt = 1'b1;
      if (w_is_code) begin
        w_idx_nxt = w_code_idx;
      end

      if (r_prev_v) begin
        case (r_state)
          ST_HUNT: begin
            if (w_legal) begin
              if (({1'b0, r_good_cnt} + 4'd1) == C_LOCK_N) begin
                w_state_nxt = ST_LOCKED;
                w_good_nxt  = 3'd0;
                w_bad_nxt   = 3'd0;
              end else begin
                w_good_nxt = r_good_cnt + 3'd1;
              end
            end else begin
              w_good_nxt = 3'd0;
            end
          end
          ST_LOCKED: begin
            if (w_legal) begin
              w_bad_nxt  = 3'd0;
              w_wrap_nxt = (r_prev == 3'd7) && (w_val == 3'd1);
            end else begin
              w_err_nxt = 1'b1;
              if (r_err_count != C_ERR_MAX) begin
                w_err_count_nxt = r_err_count + 1'b1;
              end
              if (({1'b0, r_bad_cnt} + 4'd1) == C_UNLOCK_N) begin
                w_state_nxt = ST_HUNT;
                w_good_nxt  = 3'd0;
                w_bad_nxt   = 3'd0;
              end else begin
                w_bad_nxt = r_bad_cnt + 3'd1;
              end
            end
          end
          default: w_state_nxt = ST_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HUNT;
      r_prev      <= 3'd0;
      r_prev_v    <= 1'b0;
      r_good_cnt  <= 3'd0;
      r_bad_cnt   <= 3'd0;
      r_err       <= 1'b0;
      r_err_count <= {ERR_W{1'b0}};
      r_idx       <= 3'd0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_prev_nxt;
      r_prev_v    <= w_prev_v_nxt;
      r_good_cnt  <= w_good_nxt;
      r_bad_cnt   <= w_bad_nxt;
      r_err       <= w_err_nxt;
      r_err_count <= w_err_count_nxt;
      r_idx       <= w_idx_nxt;
      r_wrap      <= w_wrap_nxt;
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err       = r_err;
  assign err_count = r_err_count;
  assign idx       = r_idx;
  assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_checker
// Description : Self-checking bench for seq_checker. Two instances are used,
//               one with ERR_W=8 and one with ERR_W=2, so that saturation can
//               be observed. A behavioural model of the stream rules runs
//               alongside the directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_checker;

  localparam int LOCK_N   = 3;
  localparam int UNLOCK_N = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [2:0] din   = 3'd0;

  logic       a_locked, a_err, a_wrap;
  logic [7:0] a_err_count;
  logic [2:0] a_idx;
  logic       b_locked, b_err, b_wrap;
  logic [1:0] b_err_count;
  logic [2:0] b_idx;

  seq_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ERR_W(8)) dut_a (
    .clock(clock), .reset(reset), .en(en), .din(din),
    .locked(a_locked), .err(a_err), .err_count(a_err_count),
    .idx(a_idx), .wrap(a_wrap)
  );

  seq_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ERR_W(2)) dut_b (
    .clock(clock), .reset(reset), .en(en), .din(din),
    .locked(b_locked), .err(b_err), .err_count(b_err_count),
    .idx(b_idx), .wrap(b_wrap)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int cyc [5] = '{1, 2, 3, 5, 7};

  int m_prev, m_good, m_bad, m_errs, m_idx;
  bit m_pv, m_locked, m_err, m_wrap;

  function automatic int pos(input int v);
    int p = -1;
    for (int i = 0; i < 5; i++) if (cyc[i] == v) p = i;
    return p;
  endfunction

  function automatic int succ(input int v);
    int p = pos(v);
    if (v == 0) return 3;
    if (p < 0) return -1;
    return cyc[(p + 1) % 5];
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    m_prev = 0; m_good = 0; m_bad = 0; m_errs = 0; m_idx = 0;
    m_pv = 0; m_locked = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_sample(input bit e, input int v);
    bit ok;
    m_err  = 0;
    m_wrap = 0;
    if (e) begin
      if (pos(v) >= 0) m_idx = pos(v);
      if (m_pv) begin
        ok = (succ(m_prev) == v);
        if (!m_locked) begin
          if (ok) begin
            m_good++;
            if (m_good == LOCK_N) begin m_locked = 1; m_good = 0; m_bad = 0; end
          end else begin
            m_good = 0;
          end
        end else if (ok) begin
          m_bad  = 0;
          m_wrap = (m_prev == 7) && (v == 1);
        end else begin
          m_err = 1;
          m_errs++;
          m_bad++;
          if (m_bad == UNLOCK_N) begin m_locked = 0; m_good = 0; m_bad = 0; end
        end
      end
      m_prev = v;
      m_pv   = 1;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      chk("a_locked", a_locked, m_locked);
      chk("a_err", a_err, m_err);
      chk("a_wrap", a_wrap, m_wrap);
      chk("a_idx", a_idx, m_idx);
      chk("a_err_count", a_err_count, min_i(m_errs, 255));
      chk("b_locked", b_locked, m_locked);
      chk("b_err", b_err, m_err);
      chk("b_wrap", b_wrap, m_wrap);
      chk("b_idx", b_idx, m_idx);
      chk("b_err_count", b_err_count, min_i(m_errs, 3));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [2:0] enc(input int v);
    logic [2:0] t;
    t = v[2:0];
    return {t[0], t[1], t[2]};
  endfunction

  task automatic step(input bit e, input int v);
    @(negedge clock);
    en  = e;
    din = enc(v);
    model_sample(e, v);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    en    = 1'b0;
    model_clear();
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    model_clear();

    // 1: entry from 0, lock, wrap
    do_reset(5);
    step(1, 0); step(1, 3); step(1, 5);
    settle(); chk("t1_locked_after_5", a_locked, 0);
    step(1, 7);
    settle(); chk("t1_locked_after_7", a_locked, 1); chk("t1_idx_after_7", a_idx, 4);
    step(1, 1);
    settle(); chk("t1_wrap", a_wrap, 1); chk("t1_idx_after_1", a_idx, 0);
    step(1, 2);
    settle(); chk("t1_wrap_clear", a_wrap, 0); chk("t1_err_count", a_err_count, 0);

    // 2: errors in LOCKED, unlock after two
    step(1, 3); step(1, 5); step(1, 6);
    settle(); chk("t2_err", a_err, 1); chk("t2_cnt1", a_err_count, 1);
    chk("t2_still_locked", a_locked, 1); chk("t2_idx_hold", a_idx, 3);
    step(1, 7);
    settle(); chk("t2_err2", a_err, 1); chk("t2_cnt2", a_err_count, 2);
    chk("t2_unlocked", a_locked, 0);

    // 3: en gaps within a legal stream
    step(1, 1); step(0, 5); step(0, 6); step(1, 2);
    settle(); chk("t3_not_locked", a_locked, 0); chk("t3_no_err", a_err, 0);
    step(1, 3);
    settle(); chk("t3_locked", a_locked, 1);

    // 4: alternate illegal/legal in LOCKED, saturate narrow counter
    for (int i = 0; i < 4; i++) begin
      step(1, 2); step(1, 3);
    end
    step(1, 2);
    settle(); chk("t4_b_err", b_err, 1); chk("t4_b_sat", b_err_count, 3);
    chk("t4_a_cnt", a_err_count, 7); chk("t4_locked", b_locked, 1);
    step(0, 0);

    // 5: asynchronous reset between edges, then relock
    @(posedge clock);
    #3;
    reset = 1'b1;
    en    = 1'b0;
    model_clear();
    #1;
    chk("t5_locked0", a_locked, 0); chk("t5_cnt0", a_err_count, 0);
    chk("t5_idx0", a_idx, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    step(1, 0); step(1, 3); step(1, 5);
    settle(); chk("t5_not_locked", a_locked, 0);
    step(1, 7);
    settle(); chk("t5_relocked", a_locked, 1);

    // 6: illegal codes in HUNT never raise err
    do_reset(2);
    step(1, 4); step(1, 6); step(1, 2);
    settle(); chk("t6_idx", a_idx, 1); chk("t6_no_err", a_err, 0);
    step(1, 3); step(1, 5);
    settle(); chk("t6_not_locked", a_locked, 0);
    step(1, 7);
    settle(); chk("t6_locked", a_locked, 1); chk("t6_cnt", a_err_count, 0);
    // 7->0 and 0->0 are illegal once locked; 0->3 is legal
    step(1, 0); step(1, 0); step(1, 3);
    settle(); chk("t6_unlocked", a_locked, 0); chk("t6_cnt2", a_err_count, 2);
    step(0, 0);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
